// File: rtl/ex_stage.sv
// ex_stage: RISC-V execute stage with forwarding, ALU, optional shift-add multiplier (RV_MUL_EN) and EX/MEM register
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            id_alu_src_a,
  input  logic            id_alu_src_b,
  input  logic [3:0]      id_alu_op,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            mem_ready,
  output logic            ex_stall,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_result,
  output logic [XLEN-1:0] ex_store_data
);
  localparam int SW = $clog2(XLEN);
  logic [XLEN-1:0] rs1_f, rs2_f, op_a, op_b, alu_res;
  logic [SW-1:0]   shamt;
  logic            start, busy, done, m_rw;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_sd, mul_res;
  assign rs1_f = forward_a == 2'b01 ? wb_fwd_data : forward_a == 2'b10 ? mem_fwd_data : id_rs1_data;
  assign rs2_f = forward_b == 2'b01 ? wb_fwd_data : forward_b == 2'b10 ? mem_fwd_data : id_rs2_data;
  assign op_a  = id_alu_src_a ? id_pc : rs1_f;
  assign op_b  = id_alu_src_b ? id_imm : rs2_f;
  assign shamt = op_b[SW-1:0];
  always_comb begin
    alu_res = '0;
    case (id_alu_op)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a << shamt;
      4'd3: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5: alu_res = op_a ^ op_b;
      4'd6: alu_res = op_a >> shamt;
      4'd7: alu_res = $signed(op_a) >>> shamt;
      4'd8: alu_res = op_a | op_b;
      4'd9: alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end
`ifdef RV_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state, state_nxt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   mplier;
  logic [SW-1:0]     cnt;
  logic              m_hi;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? BUSY : IDLE;
      BUSY:    state_nxt = cnt == SW'(XLEN-1) ? DONE : BUSY;
      DONE:    state_nxt = mem_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    start = state == IDLE && id_valid && (id_alu_op == 4'd10 || id_alu_op == 4'd11);
    busy  = state == BUSY;
    done  = state == DONE;
  end
  // operands are frozen at start so forwarding changes during BUSY cannot disturb the product
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{XLEN{1'b0}}, op_a};
      mplier <= op_b;
      cnt    <= '0;
      m_hi   <= id_alu_op[0];
      m_rd   <= id_rd;
      m_rw   <= id_reg_write;
      m_sd   <= rs2_f;
    end else if (busy) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
  assign mul_res  = m_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign ex_stall = !mem_ready | start | busy;
`else
  assign start    = 1'b0;
  assign busy     = 1'b0;
  assign done     = 1'b0;
  assign m_rw     = 1'b0;
  assign m_rd     = '0;
  assign m_sd     = '0;
  assign mul_res  = '0;
  assign ex_stall = !mem_ready;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_rd         <= '0;
      ex_result     <= '0;
      ex_store_data <= '0;
    end else if (mem_ready) begin
      ex_valid      <= done | (!start & !busy & id_valid);
      ex_reg_write  <= done ? m_rw : !start & !busy & id_valid & id_reg_write;
      ex_rd         <= done ? m_rd : id_rd;
      ex_result     <= done ? mul_res : alu_res;
      ex_store_data <= done ? m_sd : rs2_f;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against an arithmetic reference model
module tb_ex_stage;
  localparam int XLEN = 32;
  logic            clk = 1'b0, rst;
  logic            id_valid, id_reg_write, id_alu_src_a, id_alu_src_b, mem_ready;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_fwd_data, wb_fwd_data;
  logic [4:0]      id_rd;
  logic [3:0]      id_alu_op;
  logic [1:0]      forward_a, forward_b;
  logic            ex_stall, ex_valid, ex_reg_write;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result, ex_store_data;
  int checks = 0, errors = 0;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_alu_src_a(id_alu_src_a),
    .id_alu_src_b(id_alu_src_b), .id_alu_op(id_alu_op), .forward_a(forward_a),
    .forward_b(forward_b), .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .mem_ready(mem_ready), .ex_stall(ex_stall), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [1:0] s, input logic [XLEN-1:0] rf, wb, mem);
    return s == 2'd1 ? wb : s == 2'd2 ? mem : rf;
  endfunction

  function automatic logic [XLEN-1:0] alu_ref(input logic [3:0] op, input logic [XLEN-1:0] a, b);
    logic [2*XLEN-1:0] p;
    int sh;
    sh = int'(b % XLEN);
    p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd4: return (a < b) ? 1 : 0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return (a >> sh) | (a[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
      4'd8: return a | b;
      4'd9: return a & b;
`ifdef RV_MUL_EN
      4'd10: return p[XLEN-1:0];
      4'd11: return p[2*XLEN-1:XLEN];
`endif
      default: return '0;
    endcase
  endfunction

  task automatic present(input logic v, input logic [3:0] op, input logic [XLEN-1:0] r1, r2, im,
                         input logic sa, sb, input logic [1:0] fa, fb, input logic [XLEN-1:0] md, wd);
    id_valid = v; id_alu_op = op; id_rs1_data = r1; id_rs2_data = r2; id_imm = im;
    id_alu_src_a = sa; id_alu_src_b = sb; forward_a = fa; forward_b = fb;
    mem_fwd_data = md; wb_fwd_data = wd; id_pc = 32'h0000_1000; id_rd = 5'd3; id_reg_write = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef RV_MUL_EN
  task automatic run_mul(input logic [XLEN-1:0] a, b, input logic [3:0] op, input int hold);
    int pulses;
    logic [XLEN-1:0] exp;
    exp = alu_ref(op, a, b);
    pulses = 0;
    present(1'b1, op, a, b, 32'h5A5A, 1'b0, 1'b0, 2'd0, 2'd0, $urandom, $urandom);
    id_rd = 5'd9;
    mem_ready = 1'b1;
    #1;
    for (int c = 0; c <= XLEN; c++) begin
      check("mul_stall", ex_stall, 1);
      tick();
      pulses += int'(ex_valid);
      mem_fwd_data = $urandom;
      wb_fwd_data  = $urandom;
      forward_b    = 2'($urandom);
      mem_ready    = (c < XLEN) ? 1'($urandom) : 1'b1;
      #1;
    end
    forward_b = 2'd3;
    for (int h = 0; h < hold; h++) begin
      mem_ready = 1'b0;
      #1 check("mul_hold_stall", ex_stall, 1);
      tick();
      pulses += int'(ex_valid);
    end
    mem_ready = 1'b1;
    #1 check("mul_done_stall", ex_stall, 0);
    tick();
    pulses += int'(ex_valid);
    check("mul_valid", ex_valid, 1);
    check("mul_result", ex_result, exp);
    check("mul_rd", ex_rd, 9);
    check("mul_rw", ex_reg_write, 1);
    check("mul_store", ex_store_data, b);
    id_valid = 1'b0;
    repeat (3) begin
      tick();
      pulses += int'(ex_valid);
    end
    check("mul_one_pulse", pulses, 1);
  endtask
`endif

  initial begin
    logic [XLEN-1:0] a, b, e_res, e_sd;
    logic            e_v, e_rw;
    logic [4:0]      e_rd;
    int              pulses;
    e_v = 0; e_rw = 0; e_rd = 0; e_res = 0; e_sd = 0;
    rst = 1'b1;
    mem_ready = 1'b1;
    present(1'b1, 4'd0, 32'd5, 32'd7, 32'd9, 1'b0, 1'b0, 2'd2, 2'd1, 32'hAA, 32'hBB);
    forward_a = 2'd0; forward_b = 2'd0;
    repeat (2) tick();
    check("rst_valid", ex_valid, 0);
    check("rst_rw", ex_reg_write, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_result", ex_result, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_stall", ex_stall, 0);
    rst = 1'b0;
    tick();
    check("add_result", ex_result, 12);
    check("add_valid", ex_valid, 1);
    check("add_rw", ex_reg_write, 1);
    check("add_rd", ex_rd, 3);
    present(1'b1, 4'd1, 32'h99, 32'h3, 0, 1'b0, 1'b0, 2'd2, 2'd1, 32'h10, 32'h1);
    tick();
    check("sub_fwd", ex_result, 32'hF);
    check("sub_store", ex_store_data, 32'h1);
    forward_a = 2'd3;
    tick();
    check("sub_fwd11", ex_result, 32'h98);
    present(1'b1, 4'd7, 32'h8000_0000, 0, 32'h24, 1'b0, 1'b1, 2'd0, 2'd0, 0, 0);
    tick();
    check("sra", ex_result, 32'hF800_0000);
    present(1'b1, 4'd3, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);
    tick();
    check("slt", ex_result, 1);
    id_alu_op = 4'd4;
    tick();
    check("sltu", ex_result, 0);
    id_valid = 1'b0;
    tick();
    check("bubble_valid", ex_valid, 0);
    check("bubble_rw", ex_reg_write, 0);

    for (int i = 0; i < 300; i++) begin
      id_valid = 1'($urandom); id_alu_op = 4'($urandom);
`ifdef RV_MUL_EN
      if (id_alu_op == 4'd10 || id_alu_op == 4'd11) id_alu_op = 4'd0;
`endif
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : $urandom;
      id_alu_src_a = 1'($urandom); id_alu_src_b = 1'($urandom);
      forward_a = 2'($urandom); forward_b = 2'($urandom);
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      id_rd = 5'($urandom); id_reg_write = 1'($urandom);
      mem_ready = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1 check("rand_stall", ex_stall, !mem_ready);
      if (mem_ready) begin
        a = id_alu_src_a ? id_pc : fwd(forward_a, id_rs1_data, wb_fwd_data, mem_fwd_data);
        e_sd = fwd(forward_b, id_rs2_data, wb_fwd_data, mem_fwd_data);
        b = id_alu_src_b ? id_imm : e_sd;
        e_res = alu_ref(id_alu_op, a, b);
        e_v = id_valid; e_rw = id_valid & id_reg_write; e_rd = id_rd;
      end
      tick();
      check("rand_valid", ex_valid, e_v);
      check("rand_rw", ex_reg_write, e_rw);
      check("rand_rd", ex_rd, e_rd);
      check("rand_result", ex_result, e_res);
      check("rand_store", ex_store_data, e_sd);
    end
    mem_ready = 1'b1;
    id_valid = 1'b0;
    tick();

`ifdef RV_MUL_EN
    run_mul(32'hFFFF_FFFF, 32'h2, 4'd10, 0);
    run_mul(32'hFFFF_FFFF, 32'h2, 4'd11, 0);
    run_mul($urandom, $urandom, 4'd10, 3);
    run_mul($urandom, $urandom, 4'd11, 1);
    present(1'b1, 4'd10, 32'h1234, 32'h5678, 0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);
    mem_ready = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    id_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_valid", ex_valid, 0);
    check("abort_stall", ex_stall, 0);
    pulses = 0;
    repeat (XLEN + 4) begin
      tick();
      pulses += int'(ex_valid);
    end
    check("abort_no_pulse", pulses, 0);
    present(1'b1, 4'd0, 32'd1, 32'd2, 0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);
    #1 check("abort_idle_stall", ex_stall, 0);
    tick();
    check("abort_idle_add", ex_result, 3);
    check("abort_idle_valid", ex_valid, 1);
`else
    present(1'b1, 4'd10, 32'hFFFF_FFFF, 32'h2, 0, 1'b0, 1'b0, 2'd0, 2'd0, 0, 0);
    mem_ready = 1'b1;
    #1 check("nomul_stall", ex_stall, 0);
    tick();
    check("nomul_result", ex_result, 0);
    check("nomul_valid", ex_valid, 1);
    id_alu_op = 4'd11;
    tick();
    check("nomulhu_result", ex_result, 0);
    check("nomulhu_valid", ex_valid, 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
